// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the legal LATENCY range.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        SIZE_B   = 2'b00,
        SIZE_H   = 2'b01,
        SIZE_W   = 2'b10,
        SIZE_BAD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 15;
    localparam int CNT_W   = 4;

endpackage

// File: rtl/dmem_responder_lane_align.sv
// Combinational byte-lane logic: store lane merge, load extract with sign or
// zero extension, and the alignment check for half/word accesses.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  size_e       size,
    input  logic [1:0]  offs,
    input  logic        is_unsigned,
    output logic [31:0] new_word,
    output logic [31:0] rdata,
    output logic        misaligned
);

    logic [31:0]        shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    assign shifted = old_word >> {offs, 3'b000};
    assign byte_s  = shifted[7:0];
    assign half_s  = shifted[15:0];

    always_comb begin
        new_word   = old_word;
        rdata      = '0;
        misaligned = 1'b0;
        case (size)
            SIZE_B: begin
                new_word[{offs, 3'b000} +: 8] = wdata[7:0];
                if (is_unsigned) rdata = {24'b0, shifted[7:0]};
                else             rdata = 32'(byte_s);
            end
            SIZE_H: begin
                misaligned = offs[0];
                new_word[{offs[1], 4'b0000} +: 16] = wdata[15:0];
                if (is_unsigned) rdata = {16'b0, shifted[15:0]};
                else             rdata = 32'(half_s);
            end
            SIZE_W: begin
                misaligned = (offs != 2'b00);
                new_word   = wdata;
                rdata      = shifted;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder (IDLE -> WAIT -> RESP) with valid/ready
// request and response channels. Optional counters under DMEM_PERF_CNT_EN.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0] perf_rd_count,
    output logic [31:0] perf_wr_count,
    output logic [31:0] perf_err_count
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
        $error("dmem_responder: LATENCY out of range");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_error_q, rsp_error_d;
    logic               busy_q, busy_d;

    logic               wr_q;
    logic [31:0]        addr_q;
    size_e              size_q;
    logic               uns_q;
    logic [31:0]        wdata_q;
    logic               cap_en;

    logic [31:0]        mem [DEPTH_WORDS];
    logic [IDX_W-1:0]   word_idx;
    logic [31:0]        old_word;
    logic [31:0]        new_word;
    logic [31:0]        load_data;
    logic               misaligned;
    logic               out_of_range;
    logic               acc_err;
    logic               commit;
    logic               mem_we;

    assign word_idx     = addr_q[IDX_W+1:2];
    assign old_word     = mem[word_idx];
    assign out_of_range = (addr_q >= 32'(4 * DEPTH_WORDS));
    assign acc_err      = (size_q == SIZE_BAD) | misaligned | out_of_range;
    assign commit       = (state_q == ST_WAIT) && (cnt_q == '0);
    assign mem_we       = commit && wr_q && !acc_err;

    dmem_lane_align u_align (
        .old_word    (old_word),
        .wdata       (wdata_q),
        .size        (size_q),
        .offs        (addr_q[1:0]),
        .is_unsigned (uns_q),
        .new_word    (new_word),
        .rdata       (load_data),
        .misaligned  (misaligned)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        busy_d      = busy_q;
        cap_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    cap_en      = 1'b1;
                    cnt_d       = CNT_W'(LATENCY - 1);
                    state_d     = ST_WAIT;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = acc_err;
                    rsp_rdata_d = (acc_err || wr_q) ? 32'h0 : load_data;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                // req_ready rises only after the handshake edge: no back-to-back accept
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'h0;
                    rsp_error_d = 1'b0;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_error_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            busy_q      <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cap_en) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            size_q  <= size_e'(req_size);
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
        end
    end

    // Reset outranks the commit edge, so an in-flight store is dropped.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[word_idx] <= new_word;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;
    assign busy      = busy_q;

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] perf_rd_q, perf_rd_d;
    logic [31:0] perf_wr_q, perf_wr_d;
    logic [31:0] perf_err_q, perf_err_d;

    always_comb begin
        perf_rd_d  = perf_rd_q;
        perf_wr_d  = perf_wr_q;
        perf_err_d = perf_err_q;
        if (commit) begin
            if (acc_err)   perf_err_d = perf_err_q + 32'd1;
            else if (wr_q) perf_wr_d  = perf_wr_q + 32'd1;
            else           perf_rd_d  = perf_rd_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_rd_q  <= 32'h0;
            perf_wr_q  <= 32'h0;
            perf_err_q <= 32'h0;
        end else begin
            perf_rd_q  <= perf_rd_d;
            perf_wr_q  <= perf_wr_d;
            perf_err_q <= perf_err_d;
        end
    end

    assign perf_rd_count  = perf_rd_q;
    assign perf_wr_count  = perf_wr_q;
    assign perf_err_count = perf_err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-addressed
// little-endian memory model; counter checks when DMEM_PERF_CNT_EN is defined.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam int NBYTE = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        busy;
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] perf_rd_count, perf_wr_count, perf_err_count;
`endif

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .busy         (busy)
`ifdef DMEM_PERF_CNT_EN
        ,
        .perf_rd_count  (perf_rd_count),
        .perf_wr_count  (perf_wr_count),
        .perf_err_count (perf_err_count)
`endif
    );

    logic [7:0] mb [NBYTE];
    int n_chk  = 0;
    int n_pass = 0;
    int m_rd = 0, m_wr = 0, m_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic model_err(input logic [31:0] a, input logic [1:0] s);
        return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0) ||
               (a >= 32'(NBYTE));
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s,
                                               input logic u);
        int v;
        if (s == 2'd0) begin
            v = int'(mb[a]);
            if (!u && v >= 128) v = v - 256;
            return 32'(v);
        end else if (s == 2'd1) begin
            v = int'(mb[a]) + 256 * int'(mb[a+1]);
            if (!u && v >= 32768) v = v - 65536;
            return 32'(v);
        end
        return {mb[a+3], mb[a+2], mb[a+1], mb[a]};
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] wd);
        int nb;
        nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        for (int i = 0; i < nb; i++) mb[a+i] = wd[8*i +: 8];
    endtask

    // One full transaction; hold > 0 keeps rsp_ready low for that many cycles in RESP.
    task automatic xact(input logic w, input logic [31:0] a, input logic [1:0] s,
                        input logic u, input logic [31:0] wd, input int hold,
                        input string tag, output logic [31:0] rd_o, output logic err_o);
        logic        e;
        logic [31:0] exp_d;
        logic [31:0] held;
        int          lat;
        e     = model_err(a, s);
        exp_d = (!w && !e) ? model_load(a, s, u) : 32'h0;
        if (e)      m_err++;
        else if (w) m_wr++;
        else        m_rd++;
        if (w && !e) model_store(a, s, wd);

        @(posedge clk); #1;
        check_val({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_size = s;
        req_unsigned = u; req_wdata = wd; rsp_ready = (hold == 0);
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
        check_val({tag, ".busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val({tag, ".latency"}, 32'(lat), 32'(LAT));
        rd_o  = rsp_rdata;
        err_o = rsp_error;
        check_val({tag, ".rdata"}, rsp_rdata, exp_d);
        check_val({tag, ".error"}, 32'(rsp_error), 32'(e));
        if (hold > 0) begin
            held = rsp_rdata;
            repeat (hold) begin
                @(posedge clk); #1;
                check_val({tag, ".bp_valid"}, 32'(rsp_valid), 32'd1);
                check_val({tag, ".bp_rdata"}, rsp_rdata, held);
                check_val({tag, ".bp_req_ready"}, 32'(req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        check_val({tag, ".done_valid"}, 32'(rsp_valid), 32'd0);
        check_val({tag, ".done_req_ready"}, 32'(req_ready), 32'd1);
        check_val({tag, ".done_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_rd = 0; m_wr = 0; m_err = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [1:0]  s;
        logic [31:0] a;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_size = 2'd0; req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset.req_ready", 32'(req_ready), 32'd1);
        check_val("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("reset.rsp_rdata", rsp_rdata, 32'h0);
        check_val("reset.rsp_error", 32'(rsp_error), 32'd0);
        check_val("reset.busy", 32'(busy), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < DEPTH / 4; i++)
            xact(1'b1, 32'(4 * i), 2'd2, 1'b0, $urandom, 0, "init", rd, er);

        xact(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 0, "sw10", rd, er);
        check_val("sw10.ack_rdata", rd, 32'h0);
        xact(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, "lw10", rd, er);
        check_val("lw10.value", rd, 32'hDEADBEEF);
        xact(1'b1, 32'h13, 2'd0, 1'b0, 32'h00000080, 0, "sb13", rd, er);
        xact(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, "lw10b", rd, er);
        check_val("lw10b.value", rd, 32'h80ADBEEF);
        xact(1'b0, 32'h13, 2'd0, 1'b0, 32'h0, 0, "lb13", rd, er);
        check_val("lb13.value", rd, 32'hFFFFFF80);
        xact(1'b0, 32'h13, 2'd0, 1'b1, 32'h0, 0, "lbu13", rd, er);
        check_val("lbu13.value", rd, 32'h00000080);
        xact(1'b0, 32'h12, 2'd1, 1'b0, 32'h0, 0, "lh12", rd, er);
        check_val("lh12.value", rd, 32'hFFFF80AD);
        xact(1'b0, 32'h12, 2'd1, 1'b1, 32'h0, 0, "lhu12", rd, er);
        check_val("lhu12.value", rd, 32'h000080AD);

        xact(1'b0, 32'h11, 2'd1, 1'b0, 32'h0, 0, "lh11", rd, er);
        check_val("lh11.err", 32'(er), 32'd1);
        xact(1'b1, 32'h1002, 2'd2, 1'b0, 32'h11111111, 0, "sw1002", rd, er);
        check_val("sw1002.err", 32'(er), 32'd1);
        xact(1'b0, 32'h1000, 2'd2, 1'b0, 32'h0, 0, "lw1000", rd, er);
        check_val("lw1000.err", 32'(er), 32'd1);
        xact(1'b1, 32'h00000002, 2'd2, 1'b0, 32'h22222222, 0, "sw002", rd, er);
        check_val("sw002.err", 32'(er), 32'd1);
        xact(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 0, "lw000", rd, er);
        xact(1'b0, 32'h14, 2'd3, 1'b0, 32'h0, 0, "size11", rd, er);
        check_val("size11.err", 32'(er), 32'd1);

        xact(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 5, "backpressure", rd, er);
        check_val("backpressure.value", rd, 32'h80ADBEEF);

        xact(1'b1, 32'h20, 2'd2, 1'b0, 32'hCAFEF00D, 0, "sw20", rd, er);
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_size = 2'd2;
        req_unsigned = 1'b0; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_rd = 0; m_wr = 0; m_err = 0;
        check_val("midreset.busy", 32'(busy), 32'd0);
        check_val("midreset.req_ready", 32'(req_ready), 32'd1);
        check_val("midreset.rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_val("midreset.no_rsp", 32'(rsp_valid), 32'd0);
        xact(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 0, "lw20", rd, er);
        check_val("lw20.old_value", rd, 32'hCAFEF00D);

        for (int i = 0; i < 300; i++) begin
            s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) a = 32'(NBYTE) + 32'($urandom_range(0, 255));
            else begin
                a = 32'($urandom_range(0, NBYTE - 1));
                if ($urandom_range(0, 3) != 0) begin
                    if (s == 2'd1) a[0] = 1'b0;
                    if (s == 2'd2) a[1:0] = 2'b00;
                end
            end
            xact(1'($urandom_range(0, 1)), a, s, 1'($urandom_range(0, 1)), $urandom,
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0, "rand", rd, er);
        end

`ifdef DMEM_PERF_CNT_EN
        pulse_reset();
        check_val("perf.rd_reset", perf_rd_count, 32'd0);
        check_val("perf.wr_reset", perf_wr_count, 32'd0);
        check_val("perf.err_reset", perf_err_count, 32'd0);
        xact(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, "perf_l0", rd, er);
        xact(1'b1, 32'h40, 2'd1, 1'b0, 32'h0000BEEF, 0, "perf_s0", rd, er);
        xact(1'b0, 32'h41, 2'd0, 1'b1, 32'h0, 0, "perf_l1", rd, er);
        xact(1'b0, 32'h42, 2'd2, 1'b0, 32'h0, 0, "perf_e0", rd, er);
        xact(1'b1, 32'h44, 2'd2, 1'b0, 32'h01020304, 0, "perf_s1", rd, er);
        xact(1'b0, 32'h44, 2'd1, 1'b0, 32'h0, 0, "perf_l2", rd, er);
        check_val("perf.rd", perf_rd_count, 32'(m_rd));
        check_val("perf.wr", perf_wr_count, 32'(m_wr));
        check_val("perf.err", perf_err_count, 32'(m_err));
        check_val("perf.rd_plan", perf_rd_count, 32'd3);
        pulse_reset();
        check_val("perf.rd_zero", perf_rd_count, 32'd0);
        check_val("perf.wr_zero", perf_wr_count, 32'd0);
        check_val("perf.err_zero", perf_err_count, 32'd0);
`else
        pulse_reset();
        check_val("final_reset.busy", 32'(busy), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
